// File: rtl/vga_sb_pkg.sv
// Shared types and constants for the VGA system-bus controller and its fill engine.
package vga_sb_pkg;

    // Fill engine states
    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    // Word offsets inside the control page
    localparam logic [1:0] CTRL_OFF = 2'd0;
    localparam logic [1:0] DATA_OFF = 2'd1;
    localparam logic [1:0] LEN_OFF  = 2'd2;
    localparam logic [1:0] STAT_OFF = 2'd3;

    // STATUS register bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    // CTRL register start bit
    localparam int CTRL_START = 31;

    // Replace the bytes of old_val selected by be with the matching bytes of new_val
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sb_fill_engine.sv
// Fill engine: walks a region from word 0, writing one word per cycle, then flags done.
module sb_fill_engine
    import vga_sb_pkg::*;
#(
    parameter int NUM_REGIONS = 3,
    parameter int REGION_AW   = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [2:0]             target_i,
    input  logic [REGION_AW:0]     len_i,
    output logic                   busy_o,
    output logic                   fill_we_o,
    output logic [NUM_REGIONS-1:0] fill_req_o,
    output logic [REGION_AW-1:0]   fill_addr_o,
    output logic                   done_set_o,
    output logic                   err_set_o
);

    localparam logic [REGION_AW:0] DEPTH   = {1'b1, {REGION_AW{1'b0}}};
    localparam logic [2:0]         NUM_RGN = 3'(NUM_REGIONS);

    fill_state_e            state_q, state_d;
    logic [REGION_AW-1:0]   cnt_q, cnt_d;
    logic [2:0]             tgt_q, tgt_d;
    logic [REGION_AW:0]     len_q, len_d;
    logic [REGION_AW:0]     len_clamp;
    logic [REGION_AW:0]     last_idx;

    // Lengths beyond the region depth are clamped so the counter never wraps
    assign len_clamp = (len_q > DEPTH) ? DEPTH : len_q;
    assign last_idx  = len_clamp - 1'b1;

    // State, counter and latched job parameters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FILL_IDLE;
            cnt_q   <= '0;
            tgt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic and the write strobes presented to the regions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        len_d       = len_q;
        done_set_o  = 1'b0;
        err_set_o   = 1'b0;
        busy_o      = (state_q != FILL_IDLE);
        fill_we_o   = (state_q == FILL_RUN);
        fill_addr_o = cnt_q;
        fill_req_o  = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            fill_req_o[i] = (state_q == FILL_RUN) && (tgt_q == 3'(i));
        end
        case (state_q)
            FILL_IDLE: begin
                if (start_i) begin
                    tgt_d = target_i;
                    len_d = len_i;
                    cnt_d = '0;
                    if (target_i >= NUM_RGN) begin
                        state_d    = FILL_DONE;
                        done_set_o = 1'b1;
                        err_set_o  = 1'b1;
                    end else if (len_i == '0) begin
                        state_d    = FILL_DONE;
                        done_set_o = 1'b1;
                    end else begin
                        state_d = FILL_RUN;
                    end
                end
            end
            FILL_RUN: begin
                if ({1'b0, cnt_q} == last_idx) begin
                    state_d    = FILL_DONE;
                    done_set_o = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FILL_DONE: begin
                state_d = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/vga_sb_fill_ctrl.sv
// System-bus controller for N word-addressed regions plus a control page driving the fill engine.
module vga_sb_fill_ctrl
    import vga_sb_pkg::*;
#(
    parameter int NUM_REGIONS = 3,
    parameter int REGION_AW   = 10,
    parameter int SEL_LSB     = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      write_enable_i,
    input  logic [3:0]                mem_be_i,
    input  logic [31:0]               addr_i,
    input  logic [31:0]               write_data_i,
    output logic [31:0]               read_data_o,
    output logic                      ready_o,
    output logic [NUM_REGIONS-1:0]    rgn_req_o,
    output logic                      rgn_we_o,
    output logic [3:0]                rgn_be_o,
    output logic [REGION_AW-1:0]      rgn_addr_o,
    output logic [31:0]               rgn_wdata_o,
    input  logic [NUM_REGIONS*32-1:0] rgn_rdata_i
);

    localparam int            SW       = $clog2(NUM_REGIONS + 1);
    localparam logic [SW-1:0] CTRL_SEL = SW'(NUM_REGIONS);

    logic [SW-1:0]          sel;
    logic [1:0]             off;
    logic                   is_ctrl;
    logic                   busy;
    logic                   accept;
    logic                   ctrl_wr;
    logic                   cfg_wr;
    logic                   start;
    logic                   stat_clr;
    logic [2:0]             new_target;
    logic [31:0]            data_merged;
    logic [31:0]            len_merged;
    logic [31:0]            ctrl_rdata;
    logic                   unused_bits;

    logic [2:0]             target_q;
    logic [31:0]            fill_data_q;
    logic [REGION_AW:0]     fill_len_q;
    logic                   done_q;
    logic                   err_q;

    logic                   rd_vld_q;
    logic [SW-1:0]          sel_q;
    logic [31:0]            ctrl_rdata_q;

    logic                   fill_we;
    logic [NUM_REGIONS-1:0] fill_req;
    logic [REGION_AW-1:0]   fill_addr;
    logic                   done_set;
    logic                   err_set;

    assign sel     = addr_i[SEL_LSB +: SW];
    assign off     = addr_i[3:2];
    assign is_ctrl = (sel == CTRL_SEL);

    // The control page stays reachable during a fill so software can poll STATUS
    assign ready_o = is_ctrl || !busy;
    assign accept  = req_i && ready_o;

    assign ctrl_wr    = accept && is_ctrl && write_enable_i;
    assign cfg_wr     = ctrl_wr && !busy;
    assign start      = cfg_wr && (off == CTRL_OFF) && mem_be_i[3] && write_data_i[CTRL_START];
    assign stat_clr   = ctrl_wr && (off == STAT_OFF) && mem_be_i[0] && write_data_i[STAT_DONE];
    assign new_target = mem_be_i[0] ? write_data_i[2:0] : target_q;

    assign data_merged = merge_bytes(fill_data_q, write_data_i, mem_be_i);
    assign len_merged  = merge_bytes(32'(fill_len_q), write_data_i, mem_be_i);

    assign unused_bits = ^{addr_i, len_merged};

    sb_fill_engine #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_AW   (REGION_AW)
    ) u_fill (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .target_i    (new_target),
        .len_i       (fill_len_q),
        .busy_o      (busy),
        .fill_we_o   (fill_we),
        .fill_req_o  (fill_req),
        .fill_addr_o (fill_addr),
        .done_set_o  (done_set),
        .err_set_o   (err_set)
    );

    // Control registers; configuration is frozen while a fill runs, sticky flags clear before new sets
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            target_q    <= '0;
            fill_data_q <= '0;
            fill_len_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (off)
                    CTRL_OFF: begin
                        if (mem_be_i[0]) begin
                            target_q <= write_data_i[2:0];
                        end
                    end
                    DATA_OFF: fill_data_q <= data_merged;
                    LEN_OFF:  fill_len_q  <= len_merged[REGION_AW:0];
                    default:  ;
                endcase
            end
            done_q <= (done_q && !stat_clr) || done_set;
            err_q  <= (err_q && !stat_clr) || err_set;
        end
    end

    // Value a control-page read would return right now
    always_comb begin
        ctrl_rdata = '0;
        case (off)
            CTRL_OFF: ctrl_rdata[2:0] = target_q;
            DATA_OFF: ctrl_rdata = fill_data_q;
            LEN_OFF:  ctrl_rdata = 32'(fill_len_q);
            default: begin
                ctrl_rdata[STAT_BUSY] = busy;
                ctrl_rdata[STAT_DONE] = done_q;
                ctrl_rdata[STAT_ERR]  = err_q;
            end
        endcase
    end

    // Capture the read target on acceptance so the mux lines up with the region RAM latency
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_vld_q     <= 1'b0;
            sel_q        <= '0;
            ctrl_rdata_q <= '0;
        end else if (accept && !write_enable_i) begin
            rd_vld_q     <= 1'b1;
            sel_q        <= sel;
            ctrl_rdata_q <= ctrl_rdata;
        end
    end

    // Read data selector; unmapped pages return zero
    always_comb begin
        read_data_o = '0;
        if (rd_vld_q) begin
            if (sel_q == CTRL_SEL) begin
                read_data_o = ctrl_rdata_q;
            end else begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (sel_q == SW'(i)) begin
                        read_data_o = rgn_rdata_i[i*32 +: 32];
                    end
                end
            end
        end
    end

    // Region port: the fill engine owns it while busy, otherwise the core passes straight through
    always_comb begin
        rgn_req_o   = '0;
        rgn_we_o    = write_enable_i;
        rgn_be_o    = mem_be_i;
        rgn_addr_o  = addr_i[REGION_AW+1:2];
        rgn_wdata_o = write_data_i;
        if (busy) begin
            rgn_req_o   = fill_req;
            rgn_we_o    = fill_we;
            rgn_be_o    = {4{fill_we}};
            rgn_addr_o  = fill_addr;
            rgn_wdata_o = fill_data_q;
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                rgn_req_o[i] = accept && (sel == SW'(i));
            end
        end
    end

endmodule

// File: tb/tb_vga_sb_fill_ctrl.sv
// Scoreboard bench for vga_sb_fill_ctrl with region RAM models and a word-level reference model.
module tb_vga_sb_fill_ctrl;

    localparam int NR     = 3;
    localparam int AW     = 10;
    localparam int SL     = 12;
    localparam int DEPTH  = 1024;
    localparam int BUDGET = 3000;

    logic            clk;
    logic            rst_n;
    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     read_data;
    logic            ready;
    logic [NR-1:0]   rgn_req;
    logic            rgn_we;
    logic [3:0]      rgn_be;
    logic [AW-1:0]   rgn_addr;
    logic [31:0]     rgn_wdata;
    logic [NR*32-1:0] rgn_rdata;

    logic [31:0]     ram [NR][DEPTH];
    logic [31:0]     ram_rdata [NR];
    logic [31:0]     exp_mem [NR][DEPTH];
    logic [31:0]     rd_q [$];

    int              wr_cnt [NR];
    logic [AW-1:0]   last_addr;
    logic [NR-1:0]   last_req;

    int              n_checks;
    int              n_fail;

    logic [31:0]     m_data;
    logic [31:0]     m_len;
    logic [31:0]     m_target;
    logic            m_done;
    logic            m_err;

    vga_sb_fill_ctrl #(
        .NUM_REGIONS (NR),
        .REGION_AW   (AW),
        .SEL_LSB     (SL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .req_i          (req),
        .write_enable_i (we),
        .mem_be_i       (be),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (read_data),
        .ready_o        (ready),
        .rgn_req_o      (rgn_req),
        .rgn_we_o       (rgn_we),
        .rgn_be_o       (rgn_be),
        .rgn_addr_o     (rgn_addr),
        .rgn_wdata_o    (rgn_wdata),
        .rgn_rdata_i    (rgn_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rgn_rdata = {ram_rdata[2], ram_rdata[1], ram_rdata[0]};

    // Region RAMs with one-cycle read latency; output only changes on a read
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rgn_req[i]) begin
                if (rgn_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (rgn_be[b]) ram[i][rgn_addr][b*8 +: 8] <= rgn_wdata[b*8 +: 8];
                    end
                end else begin
                    ram_rdata[i] <= ram[i][rgn_addr];
                end
            end
        end
    end

    // Count every region write seen on the bus
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rgn_req[i] && rgn_we) begin
                wr_cnt[i]++;
                last_addr = rgn_addr;
                last_req  = rgn_req;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Read monitor: every accepted read is compared one cycle later against the queued expectation
    initial begin
        forever begin
            @(posedge clk);
            if (req && ready && !we) begin
                @(negedge clk);
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL read_unexpected: got 0x%08h, expected no read", read_data);
                end else begin
                    checkOutput("read_data", read_data, rd_q.pop_front());
                end
            end
        end
    end

    function automatic logic [31:0] rgn_a(input int r, input int w);
        return 32'((r << SL) | (w << 2));
    endfunction

    function automatic logic [31:0] ctl_a(input int o);
        return 32'((NR << SL) | (o << 2));
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
        logic [31:0] mask;
        mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    // One bus access: waits for ready (bounded), queues the expected read data on acceptance
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic [31:0] exp_rd, output int stalls);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = m;
        stalls = 0;
        #1;
        while (!ready && stalls <= BUDGET) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (!ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL ready_timeout: got ready=0 after %0d cycles, expected ready=1", stalls);
            req = 1'b0;
        end else begin
            if (!w) rd_q.push_back(exp_rd);
            @(posedge clk);
            #1;
            req = 1'b0; we = 1'b0;
        end
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int s;
        applyStimulus(1'b1, a, d, m, 32'h0, s);
    endtask

    task automatic do_rd(input logic [31:0] a, input logic [31:0] exp_rd);
        int s;
        applyStimulus(1'b0, a, 32'h0, 4'hF, exp_rd, s);
    endtask

    task automatic mem_wr(input int r, input int w, input logic [31:0] d, input logic [3:0] m);
        do_wr(rgn_a(r, w), d, m);
        exp_mem[r][w] = be_merge(exp_mem[r][w], d, m);
    endtask

    task automatic clear_status();
        do_wr(ctl_a(3), 32'h2, 4'hF);
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    // Program and start a fill, then check busy length, write count and STATUS against the model
    task automatic run_fill(input int tgt, input int len, input logic [31:0] d);
        int base [NR];
        int n, total, stalls, pr, pw;
        do_wr(ctl_a(1), d, 4'hF);
        do_wr(ctl_a(2), 32'(len), 4'hF);
        m_data = d;
        m_len  = 32'(len) & 32'h7FF;
        for (int i = 0; i < NR; i++) base[i] = wr_cnt[i];
        do_wr(ctl_a(0), 32'h8000_0000 | 32'(tgt), 4'hF);
        m_target = 32'(tgt & 7);
        n = (tgt < NR) ? ((int'(m_len) > DEPTH) ? DEPTH : int'(m_len)) : 0;
        for (int k = 0; k < n; k++) exp_mem[tgt][k] = d;
        m_done = 1'b1;
        if (tgt >= NR) m_err = 1'b1;
        pr = $urandom_range(0, NR - 1);
        pw = (n > 0 && pr == tgt) ? $urandom_range(0, n - 1) : $urandom_range(0, 31);
        applyStimulus(1'b0, rgn_a(pr, pw), 32'h0, 4'hF, exp_mem[pr][pw], stalls);
        checkOutput("fill_busy_cycles", 32'(stalls), 32'(n + 1));
        total = 0;
        for (int i = 0; i < NR; i++) total += wr_cnt[i] - base[i];
        checkOutput("fill_write_count", 32'(total), 32'(n));
        if (n > 0) checkOutput("fill_last_addr", 32'(last_addr), 32'(n - 1));
        do_rd(ctl_a(3), {29'h0, m_err, m_done, 1'b0});
    endtask

    initial begin
        int s, base0, base1, op, r, w;
        logic [31:0] d;
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < NR; i++) begin
            wr_cnt[i] = 0;
            ram_rdata[i] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                ram[i][k] = '0;
                exp_mem[i][k] = '0;
            end
        end
        m_data = '0; m_len = '0; m_target = '0; m_done = 1'b0; m_err = 1'b0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'h1);
        checkOutput("reset_rgn_req", 32'(rgn_req), 32'h0);
        checkOutput("reset_read_data", read_data, 32'h0);
        checkOutput("reset_rgn_we", 32'(rgn_we), 32'h0);
        checkOutput("reset_rgn_addr", 32'(rgn_addr), 32'h0);
        rst_n = 1'b1;

        $display("[TB] region write/read");
        base1 = wr_cnt[1];
        mem_wr(1, 5, 32'hDEAD_BEEF, 4'hF);
        checkOutput("core_wr_onehot", 32'(last_req), 32'h2);
        checkOutput("core_wr_count", 32'(wr_cnt[1] - base1), 32'h1);
        do_rd(rgn_a(1, 5), exp_mem[1][5]);

        $display("[TB] control byte enables");
        do_wr(ctl_a(1), 32'h1234_5678, 4'hF);
        do_wr(ctl_a(1), 32'h0000_00AA, 4'b0001);
        m_data = be_merge(be_merge(m_data, 32'h1234_5678, 4'hF), 32'h0000_00AA, 4'b0001);
        do_rd(ctl_a(1), m_data);

        $display("[TB] basic fill");
        run_fill(0, 4, 32'h0000_0F20);
        do_rd(rgn_a(0, 0), exp_mem[0][0]);
        do_rd(rgn_a(0, 3), exp_mem[0][3]);
        do_rd(rgn_a(0, 4), exp_mem[0][4]);
        clear_status();
        do_rd(ctl_a(3), 32'h0);

        $display("[TB] accesses while busy");
        base0 = wr_cnt[0];
        base1 = wr_cnt[1];
        do_wr(ctl_a(0), 32'h8000_0000, 4'hF);
        do_rd(ctl_a(3), 32'h1);
        do_wr(ctl_a(1), 32'hAAAA_5555, 4'hF);
        do_wr(ctl_a(0), 32'h8000_0001, 4'hF);
        applyStimulus(1'b0, rgn_a(0, 1), 32'h0, 4'hF, exp_mem[0][1], s);
        checkOutput("stall_remaining", 32'(s), 32'h2);
        checkOutput("ignored_start_writes", 32'(wr_cnt[1] - base1), 32'h0);
        checkOutput("first_fill_writes", 32'(wr_cnt[0] - base0), 32'h4);
        do_rd(ctl_a(1), m_data);
        do_rd(ctl_a(0), m_target);
        m_done = 1'b1;
        do_rd(ctl_a(3), 32'h2);
        clear_status();

        $display("[TB] invalid target and zero length");
        run_fill(5, 4, 32'h1111_2222);
        do_rd(ctl_a(0), 32'h5);
        clear_status();
        do_rd(ctl_a(3), 32'h0);
        run_fill(0, 0, 32'h3333_4444);
        clear_status();
        do_rd(ctl_a(3), 32'h0);

        $display("[TB] clamped full-region fill");
        run_fill(2, 32'h7FF, $urandom);
        do_rd(rgn_a(2, 1023), exp_mem[2][1023]);
        do_rd(rgn_a(2, 0), exp_mem[2][0]);
        do_rd(ctl_a(2), m_len);
        clear_status();

        $display("[TB] random traffic");
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            r  = $urandom_range(0, NR - 1);
            w  = $urandom_range(0, 31);
            d  = $urandom;
            if (op < 5) begin
                mem_wr(r, w, d, 4'($urandom_range(1, 15)));
            end else if (op < 8) begin
                do_rd(rgn_a(r, w), exp_mem[r][w]);
            end else begin
                run_fill($urandom_range(0, 5), $urandom_range(0, 24), d);
                clear_status();
            end
        end

        $display("[TB] reset during fill");
        base1 = wr_cnt[1];
        do_wr(ctl_a(2), 32'h7FF, 4'hF);
        do_wr(ctl_a(1), 32'h5A5A_5A5A, 4'hF);
        do_wr(ctl_a(0), 32'h8000_0001, 4'hF);
        s = 0;
        while ((wr_cnt[1] - base1) < 100 && s < BUDGET) begin
            @(posedge clk);
            #1;
            s++;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_rgn_req", 32'(rgn_req), 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        addr = rgn_a(0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_write_count", 32'(wr_cnt[1] - base1), 32'd100);
        checkOutput("abort_ready", 32'(ready), 32'h1);
        m_data = '0; m_len = '0; m_target = '0; m_done = 1'b0; m_err = 1'b0;
        do_rd(ctl_a(3), 32'h0);
        do_rd(ctl_a(1), m_data);
        do_rd(rgn_a(0, 2), exp_mem[0][2]);

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drain", 32'(rd_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
